// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared stopwatch types and LED timing defaults
package stopwatch_pkg;

    typedef enum logic [1:0] {
        PS_IDLE,
        PS_HIGH,
        PS_GAP
    } ps_state_t;

    localparam int LED_STRETCH_CYC = 4;
    localparam int LED_GAP_CYC     = 2;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up/down counter saturating at 0 and MAX
module sat_counter #(
    parameter int MAX = 3,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         ovf
);

    // Simultaneous inc and dec cancel, so a full counter never reports overflow then.
    assign ovf = inc && !dec && (count == W'(MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !dec && (count != W'(MAX))) begin
            count <= count + W'(1);
        end else if (dec && !inc && (count != '0)) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - stretches strobes into fixed-length levels with queued replay
module pulse_stretcher
    import stopwatch_pkg::*;
#(
    parameter int STRETCH  = LED_STRETCH_CYC,
    parameter int GAP      = LED_GAP_CYC,
    parameter int PEND_MAX = 3,
    parameter int CW       = $clog2(((STRETCH > GAP) ? STRETCH : GAP) + 1),
    parameter int PW       = $clog2(PEND_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pulse_in,
    input  logic          clr_ovf,
    output logic          level_out,
    output logic          busy,
    output logic [PW-1:0] pend_cnt,
    output logic          overflow
);

    if (STRETCH < 1 || GAP < 1 || PEND_MAX < 1) begin : g_bad_params
        $error("pulse_stretcher: STRETCH, GAP and PEND_MAX must all be >= 1");
    end

    ps_state_t      state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           level_nxt, busy_nxt;
    logic           inc, dec, drop;

    sat_counter #(.MAX(PEND_MAX), .W(PW)) u_pend (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc),
        .dec   (dec),
        .count (pend_cnt),
        .ovf   (drop)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PS_IDLE;
            cnt       <= '0;
            level_out <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            level_out <= level_nxt;
            busy      <= busy_nxt;
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = level_out;
        busy_nxt  = busy;
        inc       = 1'b0;
        dec       = 1'b0;
        case (state)
            PS_IDLE: begin
                if (pulse_in) begin
                    state_nxt = PS_HIGH;
                    cnt_nxt   = CW'(STRETCH - 1);
                    level_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                end
            end
            PS_HIGH: begin
                inc = pulse_in;
                if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                end else begin
                    state_nxt = PS_GAP;
                    cnt_nxt   = CW'(GAP - 1);
                    level_nxt = 1'b0;
                end
            end
            PS_GAP: begin
                inc = pulse_in;
                if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                end else if ((pend_cnt != '0) || pulse_in) begin
                    // A fresh strobe here pairs its inc with this dec: consumed directly.
                    dec       = 1'b1;
                    state_nxt = PS_HIGH;
                    cnt_nxt   = CW'(STRETCH - 1);
                    level_nxt = 1'b1;
                end else begin
                    state_nxt = PS_IDLE;
                    busy_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = PS_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb/tb_pulse_stretcher.sv - randomized and directed bench against a timeline model
module tb_pulse_stretcher;

    localparam int S  = 4;
    localparam int G  = 2;
    localparam int PM = 3;
    localparam int P  = S + G;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pulse_in = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       level_out;
    logic       busy;
    logic [1:0] pend_cnt;
    logic       overflow;

    int checks = 0;
    int passed = 0;

    // Model: t = edge index, last = start edge of the most recent stretched pulse,
    // p = queued events, ovf = sticky drop flag.
    int t    = 0;
    int last = -100;
    int p    = 0;
    bit ovf  = 1'b0;

    pulse_stretcher #(.STRETCH(S), .GAP(G), .PEND_MAX(PM)) dut (
        .clk       (clk),
        .rst       (rst),
        .pulse_in  (pulse_in),
        .clr_ovf   (clr_ovf),
        .level_out (level_out),
        .busy      (busy),
        .pend_cnt  (pend_cnt),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] expected();
        logic lvl, bsy;
        lvl = (t >= last) && (t - last < S);
        bsy = (t >= last) && (t < last + P);
        return {lvl, bsy, 2'(p), ovf};
    endfunction

    task automatic step(input bit r, input bit pl, input bit c);
        bit dropped;
        @(negedge clk);
        rst      = r;
        pulse_in = pl;
        clr_ovf  = c;
        @(posedge clk);
        t++;
        dropped = 1'b0;
        if (r) begin
            last = -100;
            p    = 0;
            ovf  = 1'b0;
        end else begin
            if (t >= last + P) begin
                // Previous pulse and gap complete: start the next queued or fresh event.
                if (p > 0 || pl) begin
                    last = t;
                    if (p > 0 && !pl) p--;
                end
            end else if (pl) begin
                if (p < PM) p++;
                else dropped = 1'b1;
            end
            if (dropped) ovf = 1'b1;
            else if (c) ovf = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 1'b0);
            checks++;
            if ({level_out, busy, pend_cnt, overflow} !== 5'b0) begin
                $display("FAIL reset k=%0d got %b want %b", k, {level_out, busy, pend_cnt, overflow}, 5'b0);
            end else begin
                passed++;
            end
        end
    endtask

    task automatic test_single();
        for (int k = 0; k < 10; k++) begin
            step(1'b0, k == 0, 1'b0);
            checks++;
            if ({level_out, busy, pend_cnt, overflow} !== expected()) begin
                $display("FAIL single k=%0d got %b want %b", k, {level_out, busy, pend_cnt, overflow}, expected());
            end else begin
                passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 16; k++) begin
            step(1'b0, (k == 0) || (k == 2), 1'b0);
            checks++;
            if ({level_out, busy, pend_cnt, overflow} !== expected()) begin
                $display("FAIL back_to_back k=%0d got %b want %b", k, {level_out, busy, pend_cnt, overflow}, expected());
            end else begin
                passed++;
            end
        end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 34; k++) begin
            step(1'b0, k <= 5, k == 32);
            checks++;
            if ({level_out, busy, pend_cnt, overflow} !== expected()) begin
                $display("FAIL overflow k=%0d got %b want %b", k, {level_out, busy, pend_cnt, overflow}, expected());
            end else begin
                passed++;
            end
        end
    endtask

    task automatic test_final_gap();
        for (int k = 0; k < 14; k++) begin
            step(1'b0, (k == 0) || (k == P), 1'b0);
            checks++;
            if ({level_out, busy, pend_cnt, overflow} !== expected()) begin
                $display("FAIL final_gap k=%0d got %b want %b", k, {level_out, busy, pend_cnt, overflow}, expected());
            end else begin
                passed++;
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int k = 0; k < 12; k++) begin
            step(k == 2, (k == 0) || (k == 1) || (k == 4), 1'b0);
            checks++;
            if ({level_out, busy, pend_cnt, overflow} !== expected()) begin
                $display("FAIL mid_reset k=%0d got %b want %b", k, {level_out, busy, pend_cnt, overflow}, expected());
            end else begin
                passed++;
            end
        end
    endtask

    task automatic test_set_clr();
        for (int k = 0; k < 28; k++) begin
            step(1'b0, k <= 4, (k == 4) || (k == 7));
            checks++;
            if ({level_out, busy, pend_cnt, overflow} !== expected()) begin
                $display("FAIL set_clr k=%0d got %b want %b", k, {level_out, busy, pend_cnt, overflow}, expected());
            end else begin
                passed++;
            end
        end
    endtask

    task automatic test_random();
        bit r, pl, c;
        for (int k = 0; k < 600; k++) begin
            r  = ($urandom_range(99) < 2);
            pl = ($urandom_range(99) < 35);
            c  = ($urandom_range(99) < 8);
            step(r, pl, c);
            checks++;
            if ({level_out, busy, pend_cnt, overflow} !== expected()) begin
                $display("FAIL random k=%0d got %b want %b", k, {level_out, busy, pend_cnt, overflow}, expected());
            end else begin
                passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_final_gap();
        test_mid_reset();
        test_set_clr();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
